// File: rtl/bus_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_if
// Shared local bus signals between the requesting masters and the arbiter.
//
// Parameters
//    N     number of masters
//    ID_W  width of a master index
//
// Signals (names keep the arbiter-side direction suffixes)
//    barq_i           N     bus request, one bit per master
//    bagd_o           N     bus grant, one-hot or zero
//    grant_id_o       ID_W  index of the current owner
//    busy_o           1     arbiter is in GRANT or XFER
//    address_valid_i  1     owner presents a valid address
//    target_ready_o   1     one-cycle pulse: address accepted
//    data_strobe_o    1     high in every transfer cycle
//    error_o          2     00 none, 01 address timeout, 10 hold timeout, 11 abort
//    error_id_o       ID_W  master index for error_o
//
// Modports
//    master  the requester side (drives requests and address_valid_i)
//    slave   the arbiter side (drives grants, handshake and errors)
// -----------------------------------------------------------------------------
interface bus_arbiter_rr_if #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
);

   logic [N-1:0]    barq_i;
   logic [N-1:0]    bagd_o;
   logic [ID_W-1:0] grant_id_o;
   logic            busy_o;
   logic            address_valid_i;
   logic            target_ready_o;
   logic            data_strobe_o;
   logic [1:0]      error_o;
   logic [ID_W-1:0] error_id_o;

   modport master (
      output barq_i,
      output address_valid_i,
      input  bagd_o,
      input  grant_id_o,
      input  busy_o,
      input  target_ready_o,
      input  data_strobe_o,
      input  error_o,
      input  error_id_o
   );

   modport slave (
      input  barq_i,
      input  address_valid_i,
      output bagd_o,
      output grant_id_o,
      output busy_o,
      output target_ready_o,
      output data_strobe_o,
      output error_o,
      output error_id_o
   );

endinterface

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Arbiter for N masters on the shared local bus. Grants one master at a time
// (fixed priority or round-robin), runs the address / target-ready /
// data-strobe handshake, enforces the address and hold timeouts and reports
// every error with a code and the offending master index.
//
// Parameters
//    DEVICE_MAX_NUMBER  number of masters, 2..32
//    ARB_MODE           0 = fixed priority (lowest index), 1 = round-robin
//    CLK_MAX_TIMEOUT    max GRANT cycles waiting for address_valid_i, >= 1
//    CLK_MAX_HOLD       max XFER cycles before forced release, 0 disables
//
// Ports
//    clk    system clock, rising edge
//    reset  synchronous, active-high reset
//    bus    bus_arbiter_rr_if.slave: requests/address valid in,
//           grant, owner id, busy, target ready, data strobe, error out
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
   parameter int DEVICE_MAX_NUMBER = 4,
   parameter int ARB_MODE          = 1,
   parameter int CLK_MAX_TIMEOUT   = 10,
   parameter int CLK_MAX_HOLD      = 64
) (
   input  logic             clk,
   input  logic             reset,
   bus_arbiter_rr_if.slave  bus
);

   localparam int N     = DEVICE_MAX_NUMBER;
   localparam int ID_W  = $clog2(N);
   localparam int LIM   = (CLK_MAX_TIMEOUT > CLK_MAX_HOLD) ? CLK_MAX_TIMEOUT : CLK_MAX_HOLD;
   localparam int CNT_W = $clog2(LIM + 1);

   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(CLK_MAX_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((CLK_MAX_HOLD == 0) ? 0 : CLK_MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_ADDR  = 2'b01;
   localparam logic [1:0] ERR_HOLD  = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_XFER    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [1:0]       err_code_s;

   logic [N-1:0]     bagd_q, bagd_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic             busy_q, busy_d;
   logic             target_ready_q, target_ready_d;
   logic             data_strobe_q, data_strobe_d;
   logic [1:0]       error_q, error_d;
   logic [ID_W-1:0]  error_id_q, error_id_d;

   // First requesting index at or above start, wrapping from N-1 to 0.
   function automatic logic [ID_W-1:0] pick_winner(input logic [N-1:0]    req,
                                                   input logic [ID_W-1:0] start);
      logic            found;
      logic [ID_W:0]   idx;
      pick_winner = {ID_W{1'b0}};
      found       = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, start} + (ID_W + 1)'(i);
         if (idx >= (ID_W + 1)'(N)) begin
            idx = idx - (ID_W + 1)'(N);
         end else begin
            idx = idx;
         end
         if (!found && req[idx[ID_W-1:0]]) begin
            pick_winner = idx[ID_W-1:0];
            found       = 1'b1;
         end else begin
            found = found;
         end
      end
   endfunction

   // Index following idx, wrapping from N-1 to 0.
   function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx);
      if (idx == ID_W'(N - 1)) begin
         next_index = {ID_W{1'b0}};
      end else begin
         next_index = idx + ID_W'(1);
      end
   endfunction

   // Counter increment that holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (cnt == CNT_SAT) begin
         sat_inc = cnt;
      end else begin
         sat_inc = cnt + CNT_W'(1);
      end
   endfunction

   // State, bookkeeping and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         counter_q      <= {CNT_W{1'b0}};
         ptr_q          <= {ID_W{1'b0}};
         owner_q        <= {ID_W{1'b0}};
         bagd_q         <= {N{1'b0}};
         grant_id_q     <= {ID_W{1'b0}};
         busy_q         <= 1'b0;
         target_ready_q <= 1'b0;
         data_strobe_q  <= 1'b0;
         error_q        <= 2'b00;
         error_id_q     <= {ID_W{1'b0}};
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         ptr_q          <= ptr_d;
         owner_q        <= owner_d;
         bagd_q         <= bagd_d;
         grant_id_q     <= grant_id_d;
         busy_q         <= busy_d;
         target_ready_q <= target_ready_d;
         data_strobe_q  <= data_strobe_d;
         error_q        <= error_d;
         error_id_q     <= error_id_d;
      end
   end

   // Next state, counter, pointer, owner and the error raised on this transition.
   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      err_code_s = ERR_NONE;
      case (state_q)
         S_IDLE: begin
            counter_d = {CNT_W{1'b0}};
            if (bus.barq_i != {N{1'b0}}) begin
               // Fixed priority is round-robin with the search always starting at 0.
               owner_d = pick_winner(bus.barq_i, (ARB_MODE == 0) ? {ID_W{1'b0}} : ptr_q);
               state_d = S_GRANT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            counter_d = sat_inc(counter_q);
            if (!bus.barq_i[owner_q]) begin
               err_code_s = ERR_ABORT;
               state_d    = S_RELEASE;
            end else if (bus.address_valid_i) begin
               counter_d = {CNT_W{1'b0}};
               state_d   = S_XFER;
            end else if (counter_q == TMO_LAST) begin
               err_code_s = ERR_ADDR;
               state_d    = S_RELEASE;
            end else begin
               state_d = S_GRANT;
            end
         end
         S_XFER: begin
            counter_d = sat_inc(counter_q);
            if (!bus.barq_i[owner_q]) begin
               state_d = S_RELEASE;
            end else if ((CLK_MAX_HOLD != 0) && (counter_q == HOLD_LAST)) begin
               err_code_s = ERR_HOLD;
               state_d    = S_RELEASE;
            end else begin
               state_d = S_XFER;
            end
         end
         S_RELEASE: begin
            counter_d = {CNT_W{1'b0}};
            ptr_d     = next_index(owner_q);
            state_d   = S_IDLE;
         end
         default: begin
            counter_d = {CNT_W{1'b0}};
            state_d   = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the state being entered.
   always_comb begin
      bagd_d         = {N{1'b0}};
      grant_id_d     = {ID_W{1'b0}};
      busy_d         = 1'b0;
      target_ready_d = 1'b0;
      data_strobe_d  = 1'b0;
      error_d        = ERR_NONE;
      error_id_d     = {ID_W{1'b0}};
      if ((state_d == S_GRANT) || (state_d == S_XFER)) begin
         bagd_d     = {{(N-1){1'b0}}, 1'b1} << owner_d;
         grant_id_d = owner_d;
         busy_d     = 1'b1;
      end else begin
         bagd_d = {N{1'b0}};
      end
      data_strobe_d  = (state_d == S_XFER);
      // Address acceptance is signalled only on the GRANT -> XFER step.
      target_ready_d = (state_q == S_GRANT) && (state_d == S_XFER);
      if (err_code_s != ERR_NONE) begin
         error_d    = err_code_s;
         error_id_d = owner_q;
      end else begin
         error_d = ERR_NONE;
      end
   end

   assign bus.bagd_o         = bagd_q;
   assign bus.grant_id_o     = grant_id_q;
   assign bus.busy_o         = busy_q;
   assign bus.target_ready_o = target_ready_q;
   assign bus.data_strobe_o  = data_strobe_q;
   assign bus.error_o        = error_q;
   assign bus.error_id_o     = error_id_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Two arbiters share one stimulus stream: a round-robin one with an 8-cycle
// hold limit and a fixed-priority one with the hold check disabled. A
// transaction-level model tracks each arbiter's bus phase, owner and pointer
// and is compared against both every falling edge; a few directed scenarios
// pin known values before a randomized run.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

   localparam int N   = 4;
   localparam int TMO = 10;

   logic       clk;
   logic       reset;
   logic [3:0] barq;
   logic       av;

   bus_arbiter_rr_if #(.N(N)) if_rr ();
   bus_arbiter_rr_if #(.N(N)) if_fp ();

   assign if_rr.barq_i          = barq;
   assign if_rr.address_valid_i = av;
   assign if_fp.barq_i          = barq;
   assign if_fp.address_valid_i = av;

   bus_arbiter_rr #(
      .DEVICE_MAX_NUMBER (N),
      .ARB_MODE          (1),
      .CLK_MAX_TIMEOUT   (TMO),
      .CLK_MAX_HOLD      (8)
   ) dut_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (if_rr.slave)
   );

   bus_arbiter_rr #(
      .DEVICE_MAX_NUMBER (N),
      .ARB_MODE          (0),
      .CLK_MAX_TIMEOUT   (TMO),
      .CLK_MAX_HOLD      (0)
   ) dut_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (if_fp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   // Model: phase 0 idle, 1 waiting for address, 2 transferring, 3 turnaround
   int m_phase [2];
   int m_age   [2];
   int m_owner [2];
   int m_ptr   [2];
   int e_bagd  [2];
   int e_busy  [2];
   int e_tr    [2];
   int e_stb   [2];
   int e_err   [2];
   int e_eid   [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int winner(input logic [3:0] req, input int start);
      for (int i = 0; i < N; i++) begin
         if (req[(start + i) % N]) return (start + i) % N;
      end
      return 0;
   endfunction

   // Advance model k by one clock using the inputs present at the edge.
   task automatic model_step(input int k);
      int  hold;
      int  code;
      bit  rel;
      hold = (k == 0) ? 8 : 0;
      code = 0;
      rel  = 1'b0;
      e_tr[k] = 0;
      if (reset) begin
         m_phase[k] = 0; m_age[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
      end else begin
         case (m_phase[k])
            0: if (barq != 4'b0000) begin
                  m_owner[k] = winner(barq, (k == 0) ? m_ptr[k] : 0);
                  m_phase[k] = 1;
                  m_age[k]   = 0;
               end
            1: if (!barq[m_owner[k]]) begin
                  code = 3; rel = 1'b1;
               end else if (av) begin
                  m_phase[k] = 2; m_age[k] = 0; e_tr[k] = 1;
               end else if (m_age[k] + 1 == TMO) begin
                  code = 1; rel = 1'b1;
               end else begin
                  m_age[k]++;
               end
            2: if (!barq[m_owner[k]]) begin
                  rel = 1'b1;
               end else if (hold != 0 && m_age[k] + 1 == hold) begin
                  code = 2; rel = 1'b1;
               end else begin
                  m_age[k]++;
               end
            default: begin
               m_phase[k] = 0;
               m_ptr[k]   = (m_owner[k] + 1) % N;
            end
         endcase
      end
      if (rel) m_phase[k] = 3;
      e_err[k]  = code;
      e_eid[k]  = (code != 0) ? m_owner[k] : 0;
      e_busy[k] = (m_phase[k] == 1 || m_phase[k] == 2) ? 1 : 0;
      e_stb[k]  = (m_phase[k] == 2) ? 1 : 0;
      e_bagd[k] = e_busy[k] ? (1 << m_owner[k]) : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      started = 1'b1;
      #1;
   endtask

   // Model-vs-DUT comparison on every falling edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("rr bagd", 32'(if_rr.bagd_o), 32'(e_bagd[0]));
         chk("rr busy", 32'(if_rr.busy_o), 32'(e_busy[0]));
         if (e_busy[0] != 0) chk("rr grant_id", 32'(if_rr.grant_id_o), 32'(m_owner[0]));
         chk("rr target_ready", 32'(if_rr.target_ready_o), 32'(e_tr[0]));
         chk("rr data_strobe", 32'(if_rr.data_strobe_o), 32'(e_stb[0]));
         chk("rr error", 32'(if_rr.error_o), 32'(e_err[0]));
         chk("rr error_id", 32'(if_rr.error_id_o), 32'(e_eid[0]));
         chk("fp bagd", 32'(if_fp.bagd_o), 32'(e_bagd[1]));
         chk("fp busy", 32'(if_fp.busy_o), 32'(e_busy[1]));
         if (e_busy[1] != 0) chk("fp grant_id", 32'(if_fp.grant_id_o), 32'(m_owner[1]));
         chk("fp target_ready", 32'(if_fp.target_ready_o), 32'(e_tr[1]));
         chk("fp data_strobe", 32'(if_fp.data_strobe_o), 32'(e_stb[1]));
         chk("fp error", 32'(if_fp.error_o), 32'(e_err[1]));
         chk("fp error_id", 32'(if_fp.error_id_o), 32'(e_eid[1]));
      end
   end

   initial begin
      reset = 1'b1;
      barq  = 4'b0000;
      av    = 1'b0;
      tick();
      tick();
      chk("reset bagd", 32'(if_rr.bagd_o), 32'd0);
      chk("reset busy", 32'(if_rr.busy_o), 32'd0);
      chk("reset error", 32'(if_rr.error_o), 32'd0);
      chk("reset strobe", 32'(if_rr.data_strobe_o), 32'd0);

      // Address timeout on master 2
      reset = 1'b0;
      barq  = 4'b0100;
      tick();
      chk("tmo grant", 32'(if_rr.bagd_o), 32'd4);
      chk("tmo grant_id", 32'(if_rr.grant_id_o), 32'd2);
      chk("tmo busy", 32'(if_rr.busy_o), 32'd1);
      repeat (9) tick();
      chk("tmo still granted", 32'(if_rr.busy_o), 32'd1);
      chk("tmo no early error", 32'(if_rr.error_o), 32'd0);
      tick();
      chk("tmo error", 32'(if_rr.error_o), 32'd1);
      chk("tmo error_id", 32'(if_rr.error_id_o), 32'd2);
      chk("tmo released", 32'(if_rr.bagd_o), 32'd0);
      barq = 4'b0000;
      tick();
      chk("tmo error one cycle", 32'(if_rr.error_o), 32'd0);
      tick();

      // Owner 3 aborts during GRANT
      barq = 4'b1000;
      tick();
      chk("abort grant_id", 32'(if_rr.grant_id_o), 32'd3);
      repeat (3) begin
         tick();
         chk("abort no target_ready", 32'(if_rr.target_ready_o), 32'd0);
      end
      barq = 4'b0000;
      tick();
      chk("abort error", 32'(if_rr.error_o), 32'd3);
      chk("abort error_id", 32'(if_rr.error_id_o), 32'd3);
      chk("abort no target_ready at release", 32'(if_rr.target_ready_o), 32'd0);
      tick();

      // Hold timeout on owner 0, then pointer moves to 1
      barq = 4'b0001;
      tick();
      chk("hold grant_id", 32'(if_rr.grant_id_o), 32'd0);
      av = 1'b1;
      tick();
      av = 1'b0;
      chk("hold target_ready", 32'(if_rr.target_ready_o), 32'd1);
      chk("hold strobe first", 32'(if_rr.data_strobe_o), 32'd1);
      repeat (7) begin
         tick();
         chk("hold strobe", 32'(if_rr.data_strobe_o), 32'd1);
         chk("hold target_ready pulse", 32'(if_rr.target_ready_o), 32'd0);
      end
      tick();
      chk("hold error", 32'(if_rr.error_o), 32'd2);
      chk("hold error_id", 32'(if_rr.error_id_o), 32'd0);
      chk("hold strobe off", 32'(if_rr.data_strobe_o), 32'd0);
      chk("fp hold disabled", 32'(if_fp.data_strobe_o), 32'd1);
      barq = 4'b0011;
      tick();
      tick();
      chk("pointer after hold", 32'(if_rr.grant_id_o), 32'd1);

      // Reset during XFER
      av = 1'b1;
      tick();
      av = 1'b0;
      chk("xfer before reset", 32'(if_rr.data_strobe_o), 32'd1);
      reset = 1'b1;
      tick();
      chk("mid reset bagd", 32'(if_rr.bagd_o), 32'd0);
      chk("mid reset busy", 32'(if_rr.busy_o), 32'd0);
      chk("mid reset strobe", 32'(if_rr.data_strobe_o), 32'd0);
      chk("mid reset error", 32'(if_rr.error_o), 32'd0);
      reset = 1'b0;
      barq  = 4'b1111;
      tick();
      chk("pointer after reset", 32'(if_rr.grant_id_o), 32'd0);

      // Fixed priority starves master 3; round-robin alternates
      reset = 1'b1;
      tick();
      reset = 1'b0;
      barq  = 4'b1010;
      tick();
      chk("fp first grant", 32'(if_fp.grant_id_o), 32'd1);
      chk("rr first grant", 32'(if_rr.grant_id_o), 32'd1);
      repeat (10) tick();
      chk("fp timeout", 32'(if_fp.error_o), 32'd1);
      tick();
      tick();
      chk("fp second grant", 32'(if_fp.grant_id_o), 32'd1);
      chk("rr second grant", 32'(if_rr.grant_id_o), 32'd3);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 15) == 0) barq[b] = ~barq[b];
         end
         av    = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end

      reset = 1'b0;
      tick();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
